// File: rtl/smvm_result_collector.sv
// Result collector for the SMVM core. It buffers the unthrottled row-result stream in a show-ahead FIFO,
// frames each operation as ROWS results for a valid/ready host port, and flags dropped or surplus results.
module smvm_result_collector #(
  parameter int DATA_W = 13,
  parameter int ROW_W  = 9,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ROW_W-1:0]  rows_in,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              excess
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [ROW_W:0] CNT_ONE = {{ROW_W{1'b0}}, 1'b1};

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr_reg, rd_ptr_reg;
  logic [ROW_W:0]    rows_reg, rx_cnt_reg, tx_cnt_reg, drop_cnt_reg;
  logic [ROW_W:0]    last_idx;
  logic              done_reg, overflow_reg, excess_reg;
  logic              run, empty, full, pop, push_req, push, drop, extra;
  logic              last_pop, drain_exit, launch, zero_op;

  assign run   = (state_reg == RUN);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                 (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

  // Last marks the final entry actually stored, so drops shorten the frame.
  assign last_idx  = rows_reg - drop_cnt_reg - CNT_ONE;
  assign out_valid = run & ~empty;
  assign out_data  = out_valid ? mem[rd_ptr_reg[PTR_W-1:0]] : '0;
  assign out_last  = out_valid & (tx_cnt_reg == last_idx);
  assign busy      = run;
  assign done      = done_reg;
  assign overflow  = overflow_reg;
  assign excess    = excess_reg;

  assign pop      = out_valid & out_ready;
  assign push_req = in_valid & run & (rx_cnt_reg < rows_reg);
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign extra    = in_valid & run & (rx_cnt_reg >= rows_reg);
  assign last_pop = pop & out_last;
  // Every remaining result was dropped: nothing left to mark as last.
  assign drain_exit = run & empty & (rx_cnt_reg == rows_reg);
  assign launch     = ~run & start & (rows_in != '0);
  assign zero_op    = ~run & start & (rows_in == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (launch) state_next = RUN;
      RUN:     if (last_pop || drain_exit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[PTR_W-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_reg     <= '0;
      rx_cnt_reg   <= '0;
      tx_cnt_reg   <= '0;
      drop_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      excess_reg   <= 1'b0;
    end else begin
      done_reg <= last_pop | drain_exit | zero_op;
      if (launch) begin
        rows_reg     <= {1'b0, rows_in};
        rx_cnt_reg   <= '0;
        tx_cnt_reg   <= '0;
        drop_cnt_reg <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        overflow_reg <= 1'b0;
        excess_reg   <= 1'b0;
      end else begin
        if (push)     wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (push_req) rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
          tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
        end
        if (drop) begin
          drop_cnt_reg <= drop_cnt_reg + CNT_ONE;
          overflow_reg <= 1'b1;
        end
        if (extra) excess_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_smvm_result_collector.sv
// Bench for smvm_result_collector: table-driven basic frame, directed corner sequences,
// and randomized operations checked every cycle against a queue-based reference model.
module tb_smvm_result_collector;
  localparam int DATA_W = 13;
  localparam int ROW_W  = 9;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ROW_W-1:0]  rows_in = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              out_ready = 1'b0;
  logic              out_valid, out_last, busy, done, overflow, excess;
  logic [DATA_W-1:0] out_data;

  smvm_result_collector #(.DATA_W(DATA_W), .ROW_W(ROW_W), .DEPTH(DEPTH), .PTR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rows_in(rows_in), .in_valid(in_valid),
    .data_in(data_in), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .overflow(overflow), .excess(excess)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: operation state as plain integers plus a queue for the stored results.
  bit                m_run, m_done, m_ovf, m_exc;
  int                m_rows, m_rx, m_tx, m_drop;
  logic [DATA_W-1:0] mq[$];

  // Results the host actually received.
  logic [DATA_W-1:0] got_q[$];
  bit                got_last[$];

  typedef struct {
    bit                st;
    int                rw;
    bit                iv;
    logic [DATA_W-1:0] d;
    bit                rdy;
    bit                e_valid;
    logic [DATA_W-1:0] e_data;
    bit                e_last;
    bit                e_busy;
    bit                e_done;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_exc = 1'b0;
    m_rows = 0; m_rx = 0; m_tx = 0; m_drop = 0;
    mq.delete();
  endtask

  task automatic model_step(input bit st, input int rw, input bit iv,
                            input logic [DATA_W-1:0] d, input bit rdy);
    int sz0;
    bit pop, lst, drain;
    sz0   = mq.size();
    pop   = m_run && (sz0 > 0) && rdy;
    lst   = pop && (m_tx == m_rows - 1 - m_drop);
    drain = m_run && (sz0 == 0) && (m_rx == m_rows);
    m_done = 1'b0;
    if (!m_run) begin
      if (st && rw == 0) m_done = 1'b1;
      else if (st) begin
        m_run = 1'b1; m_rows = rw; m_rx = 0; m_tx = 0; m_drop = 0;
        m_ovf = 1'b0; m_exc = 1'b0; mq.delete();
      end
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_tx++;
      end
      if (iv) begin
        if (m_rx < m_rows) begin
          if (sz0 < DEPTH || pop) mq.push_back(d);
          else begin m_drop++; m_ovf = 1'b1; end
          m_rx++;
        end else m_exc = 1'b1;
      end
      if (lst || drain) begin m_run = 1'b0; m_done = 1'b1; end
    end
  endtask

  task automatic check_vs_model();
    bit e_valid, e_last;
    e_valid = m_run && (mq.size() > 0);
    e_last  = e_valid && (m_tx == m_rows - 1 - m_drop);
    check("out_valid", 32'(out_valid), 32'(e_valid));
    if (e_valid) check("out_data", 32'(out_data), 32'(mq[0]));
    check("out_last", 32'(out_last), 32'(e_last));
    check("busy", 32'(busy), 32'(m_run));
    check("done", 32'(done), 32'(m_done));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("excess", 32'(excess), 32'(m_exc));
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic cyc(input bit st, input int rw, input bit iv,
                     input logic [DATA_W-1:0] d, input bit rdy);
    check_vs_model();
    start = st; rows_in = rw[ROW_W-1:0]; in_valid = iv; data_in = d; out_ready = rdy;
    #1;
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_last.push_back(out_last);
      $display("xfer #%0d data=0x%04h last=%0b", got_q.size() - 1, out_data, out_last);
    end
    @(posedge clk);
    model_step(st, rw, iv, d, rdy);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int maxc);
    for (int k = 0; k < maxc && m_run; k++) cyc(1'b0, 0, 1'b0, '0, 1'b1);
    check({name, "_drained"}, 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rows_in = '0; data_in = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_excess", 32'(excess), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_got();
    got_q.delete();
    got_last.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] v[20];
    logic [31:0] r;
    int lasts;

    // Basic 4-row frame: {start, rows, in_valid, data, ready, exp valid, data, last, busy, done}
    tbl[0] = '{1'b1, 4, 1'b0, 13'h0000, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 0, 1'b1, 13'h0011, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 0, 1'b1, 13'h0022, 1'b1, 1'b1, 13'h0011, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 0, 1'b1, 13'h1FFF, 1'b1, 1'b1, 13'h0022, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 0, 1'b1, 13'h0000, 1'b1, 1'b1, 13'h1FFF, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 0, 1'b0, 13'h0000, 1'b1, 1'b1, 13'h0000, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 0, 1'b0, 13'h0000, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 0, 1'b0, 13'h0000, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0};

    @(negedge clk);
    apply_reset();

    // T1 basic
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_valid[%0d]", i), 32'(out_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) check($sformatf("t1_data[%0d]", i), 32'(out_data), 32'(tbl[i].e_data));
      check($sformatf("t1_last[%0d]", i), 32'(out_last), 32'(tbl[i].e_last));
      check($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("t1_done[%0d]", i), 32'(done), 32'(tbl[i].e_done));
      cyc(tbl[i].st, tbl[i].rw, tbl[i].iv, tbl[i].d, tbl[i].rdy);
    end

    // T2 backpressure
    clear_got();
    for (int i = 0; i < 8; i++) begin r = $urandom; v[i] = r[DATA_W-1:0]; end
    cyc(1'b1, 8, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 0, 1'b1, v[i], 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("t2_hold_valid", 32'(out_valid), 32'd1);
      check("t2_hold_data", 32'(out_data), 32'(v[0]));
      cyc(1'b0, 0, 1'b0, '0, 1'b0);
    end
    drain("t2", 100);
    check("t2_done", 32'(done), 32'd1);
    check("t2_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      check($sformatf("t2_order[%0d]", i), 32'(got_q[i]), 32'(v[i]));
    check("t2_overflow", 32'(overflow), 32'd0);

    // T3 overflow
    clear_got();
    for (int i = 0; i < 20; i++) begin r = $urandom; v[i] = r[DATA_W-1:0]; end
    cyc(1'b1, 20, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 0, 1'b1, v[i], 1'b0);
    check("t3_overflow", 32'(overflow), 32'd1);
    drain("t3", 100);
    check("t3_done", 32'(done), 32'd1);
    check("t3_count", 32'(got_q.size()), 32'd16);
    lasts = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (i < 16) check($sformatf("t3_order[%0d]", i), 32'(got_q[i]), 32'(v[i]));
      if (got_last[i]) lasts++;
    end
    if (got_last.size() == 16) check("t3_last_on_16th", 32'(got_last[15]), 32'd1);
    check("t3_last_count", 32'(lasts), 32'd1);

    // T4 full FIFO with simultaneous pop and push
    clear_got();
    for (int i = 0; i < 17; i++) begin r = $urandom; v[i] = r[DATA_W-1:0]; end
    cyc(1'b1, 17, 1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 0, 1'b1, v[i], 1'b0);
    cyc(1'b0, 0, 1'b1, v[16], 1'b1);
    check("t4_overflow", 32'(overflow), 32'd0);
    drain("t4", 100);
    check("t4_count", 32'(got_q.size()), 32'd17);
    if (got_q.size() == 17) begin
      check("t4_tail", 32'(got_q[16]), 32'(v[16]));
      check("t4_tail_last", 32'(got_last[16]), 32'd1);
    end

    // T5 framing: excess, cleared by next start, then a zero-row operation
    clear_got();
    cyc(1'b1, 2, 1'b0, '0, 1'b0);
    cyc(1'b0, 0, 1'b1, 13'h0AAA, 1'b0);
    cyc(1'b0, 0, 1'b1, 13'h0555, 1'b0);
    cyc(1'b0, 0, 1'b1, 13'h1234, 1'b0);
    check("t5_excess", 32'(excess), 32'd1);
    drain("t5a", 50);
    check("t5_count", 32'(got_q.size()), 32'd2);
    cyc(1'b1, 1, 1'b0, '0, 1'b0);
    check("t5_excess_cleared", 32'(excess), 32'd0);
    cyc(1'b0, 0, 1'b1, 13'h0777, 1'b1);
    drain("t5b", 50);
    cyc(1'b1, 0, 1'b0, '0, 1'b1);
    check("t5_zero_done", 32'(done), 32'd1);
    check("t5_zero_busy", 32'(busy), 32'd0);
    cyc(1'b0, 0, 1'b0, '0, 1'b1);
    cyc(1'b0, 0, 1'b0, '0, 1'b1);

    // T6 reset mid-operation with 5 results queued
    cyc(1'b1, 10, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 0, 1'b1, 13'(i + 1), 1'b0);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    apply_reset();
    clear_got();
    cyc(1'b1, 1, 1'b0, '0, 1'b1);
    check("t6_fifo_empty", 32'(out_valid), 32'd0);
    cyc(1'b0, 0, 1'b1, 13'h0BEE, 1'b1);
    drain("t6", 50);
    check("t6_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("t6_data", 32'(got_q[0]), 32'h0BEE);

    // Randomized operations against the model
    for (int op = 0; op < 25; op++) begin
      int rw, extra, sent, total;
      bit iv, st, rdy;
      logic [DATA_W-1:0] d;
      rw    = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      total = (rw == 0) ? 0 : rw + extra;
      sent  = 0;
      cyc(1'b1, rw, 1'b0, '0, ($urandom_range(0, 1) != 0));
      for (int k = 0; k < 600; k++) begin
        if (!m_run && sent >= total) break;
        iv  = (sent < total) && ($urandom_range(0, 3) != 0);
        st  = m_run && ($urandom_range(0, 15) == 0);
        rdy = ($urandom_range(0, 3) != 0);
        r = $urandom; d = r[DATA_W-1:0];
        cyc(st, int'($urandom_range(0, 40)), iv, d, rdy);
        if (iv) sent++;
      end
      check($sformatf("rand_op%0d_finished", op), 32'(busy), 32'd0);
      cyc(1'b0, 0, 1'b0, '0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
